// File: rtl/priority_isr_ctrl.sv
// priority_isr_ctrl: 8-level priority interrupt controller in fully nested
// mode. The controller arbitrates IRR & ~IMR, answers a two-pulse INTA
// sequence (first pulse latches the level, second drives the vector) and
// clears in-service bits on EOI or automatically (AUTO_EOI=1).
// Optional macro PIC_AUTO_ROTATE_EN: each non-specific EOI makes the level
// it cleared the lowest priority. Without it, IR0 is always highest.
// Handshake: inta and eoi are single-cycle pulses sampled on the rising edge
// of clk. All outputs are registered and show the effect of a pulse in the
// cycle after the edge that sampled it. irr_clr and vector_oe are one-cycle
// pulses. vector holds its value while vector_oe is low.
module priority_isr_ctrl #(
    parameter int AUTO_EOI = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic       inta,
    input  logic       eoi,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic [4:0] vec_base,
    output logic       int_out,
    output logic [7:0] irr_clr,
    output logic [7:0] isr,
    output logic [7:0] vector,
    output logic       vector_oe,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] level_q, level_d;
    logic       spur_q, spur_d;
    logic       int_out_q, int_out_d;
    logic [7:0] irr_clr_q, irr_clr_d;
    logic [7:0] vector_q, vector_d;
    logic       vector_oe_q, vector_oe_d;
`ifdef PIC_AUTO_ROTATE_EN
    logic [2:0] lowest_q, lowest_d;
`endif

    // Priority order is described by the level that is currently lowest;
    // the level right after it (mod 8) is the highest.
    logic [2:0] pri_cur, pri_nxt;
    logic [7:0] elig;
    logic [3:0] win, isr_top, win_nxt, isr_top_nxt;

    // Returns {found, level} of the highest-priority set bit of vec.
    function automatic logic [3:0] find_top(input logic [7:0] vec, input logic [2:0] lowest);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            lvl = lowest + 3'd1 + 3'(k);
            if (vec[lvl]) res = {1'b1, lvl};
        end
        return res;
    endfunction

    // Rank 0 is the highest priority.
    function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lowest);
        return lvl - lowest - 3'd1;
    endfunction

    // Next-state: EOI acts on the pre-cycle ISR, then the INTA sequence applies.
    always_comb begin
        state_d     = state_q;
        isr_d       = isr_q;
        level_d     = level_q;
        spur_d      = spur_q;
        irr_clr_d   = 8'd0;
        vector_d    = vector_q;
        vector_oe_d = 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
        lowest_d    = lowest_q;
        pri_cur     = lowest_q;
`else
        pri_cur     = 3'd7;
`endif
        elig    = irr & ~imr;
        win     = find_top(elig, pri_cur);
        isr_top = find_top(isr_q, pri_cur);

        if (eoi) begin
            if (eoi_specific) begin
                isr_d[eoi_level] = 1'b0;
            end else if (isr_top[3]) begin
                isr_d[isr_top[2:0]] = 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
                lowest_d = isr_top[2:0];
`endif
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (inta) begin
                    state_d = ST_ACK1;
                    if (win[3]) begin
                        level_d             = win[2:0];
                        spur_d              = 1'b0;
                        isr_d[win[2:0]]     = 1'b1;
                        irr_clr_d[win[2:0]] = 1'b1;
                    end else begin
                        level_d = 3'd7;
                        spur_d  = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta) begin
                    state_d     = ST_ACK2;
                    vector_d    = {vec_base, level_q};
                    vector_oe_d = 1'b1;
                    if (AUTO_EOI != 0 && !spur_q) isr_d[level_q] = 1'b0;
                end
            end
            ST_ACK2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

`ifdef PIC_AUTO_ROTATE_EN
        pri_nxt = lowest_d;
`else
        pri_nxt = 3'd7;
`endif
        win_nxt     = find_top(elig, pri_nxt);
        isr_top_nxt = find_top(isr_d, pri_nxt);
        int_out_d   = win_nxt[3] &&
                      (!isr_top_nxt[3] || (rank(win_nxt[2:0], pri_nxt) < rank(isr_top_nxt[2:0], pri_nxt)));
    end

    // State and output registers; reset abandons any acknowledge in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            isr_q       <= 8'd0;
            level_q     <= 3'd0;
            spur_q      <= 1'b0;
            int_out_q   <= 1'b0;
            irr_clr_q   <= 8'd0;
            vector_q    <= 8'd0;
            vector_oe_q <= 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
            lowest_q    <= 3'd7;
`endif
        end else begin
            state_q     <= state_d;
            isr_q       <= isr_d;
            level_q     <= level_d;
            spur_q      <= spur_d;
            int_out_q   <= int_out_d;
            irr_clr_q   <= irr_clr_d;
            vector_q    <= vector_d;
            vector_oe_q <= vector_oe_d;
`ifdef PIC_AUTO_ROTATE_EN
            lowest_q    <= lowest_d;
`endif
        end
    end

    assign int_out   = int_out_q;
    assign irr_clr   = irr_clr_q;
    assign isr       = isr_q;
    assign vector    = vector_q;
    assign vector_oe = vector_oe_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_priority_isr_ctrl.sv
// Bench for priority_isr_ctrl: two instances (AUTO_EOI=0 and AUTO_EOI=1)
// share stimulus; a priority-list model per instance predicts every output
// each cycle, and directed scenarios add literal expectations.
module tb_priority_isr_ctrl;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] irr = 8'd0;
    logic [7:0] imr = 8'd0;
    logic       inta = 1'b0;
    logic       eoi = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic [4:0] vec_base = 5'd0;

    logic       int_out_v [2];
    logic [7:0] irr_clr_v [2];
    logic [7:0] isr_v     [2];
    logic [7:0] vector_v  [2];
    logic       voe_v     [2];
    logic [1:0] st_v      [2];

    int  n_pass = 0;
    int  n_total = 0;
    bit  cmp_en = 1'b0;

    always #5 clk = ~clk;

    priority_isr_ctrl #(.AUTO_EOI(0)) dut0 (
        .clk(clk), .reset(reset), .irr(irr), .imr(imr), .inta(inta), .eoi(eoi),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .vec_base(vec_base),
        .int_out(int_out_v[0]), .irr_clr(irr_clr_v[0]), .isr(isr_v[0]),
        .vector(vector_v[0]), .vector_oe(voe_v[0]), .state_dbg(st_v[0])
    );

    priority_isr_ctrl #(.AUTO_EOI(1)) dut1 (
        .clk(clk), .reset(reset), .irr(irr), .imr(imr), .inta(inta), .eoi(eoi),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .vec_base(vec_base),
        .int_out(int_out_v[1]), .irr_clr(irr_clr_v[1]), .isr(isr_v[1]),
        .vector(vector_v[1]), .vector_oe(voe_v[1]), .state_dbg(st_v[1])
    );

    // ---------------- reference model ----------------
    // Phase 0 = idle, 1 = first ack taken, 2 = vector delivered.
    int         m_phase [2];
    logic [7:0] m_isr   [2];
    int         m_lvl   [2];
    bit         m_spur  [2];
    logic       m_int   [2];
    logic [7:0] m_clr   [2];
    logic [7:0] m_vec   [2];
    logic       m_voe   [2];
    int         m_order [2][8];   // m_order[i][0] is the highest priority level

    function automatic int top_of(input logic [7:0] v, input int i);
        for (int k = 0; k < 8; k++)
            if (v[m_order[i][k]]) return m_order[i][k];
        return -1;
    endfunction

    function automatic int pos_of(input int lvl, input int i);
        for (int k = 0; k < 8; k++)
            if (m_order[i][k] == lvl) return k;
        return 8;
    endfunction

    task automatic move_to_end(input int i, input int lvl);
        int q[$];
        for (int k = 0; k < 8; k++)
            if (m_order[i][k] != lvl) q.push_back(m_order[i][k]);
        q.push_back(lvl);
        for (int k = 0; k < 8; k++) m_order[i][k] = q[k];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_isr[i] = 8'd0; m_lvl[i] = 0; m_spur[i] = 1'b0;
            m_int[i] = 1'b0; m_clr[i] = 8'd0; m_vec[i] = 8'd0; m_voe[i] = 1'b0;
            for (int k = 0; k < 8; k++) m_order[i][k] = k;
        end
    endtask

    task automatic model_step(input int i, input bit auto_eoi);
        logic [7:0] elig, nxt;
        int w, t, w2, t2;
        elig = irr & ~imr;
        nxt  = m_isr[i];
        w    = top_of(elig, i);
        if (eoi) begin
            if (eoi_specific) begin
                nxt[eoi_level] = 1'b0;
            end else begin
                t = top_of(m_isr[i], i);
                if (t >= 0) begin
                    nxt[t] = 1'b0;
`ifdef PIC_AUTO_ROTATE_EN
                    move_to_end(i, t);
`endif
                end
            end
        end
        m_clr[i] = 8'd0;
        m_voe[i] = 1'b0;
        if (m_phase[i] == 0) begin
            if (inta) begin
                m_phase[i] = 1;
                if (w >= 0) begin
                    nxt[w] = 1'b1; m_clr[i] = 8'(1 << w); m_lvl[i] = w; m_spur[i] = 1'b0;
                end else begin
                    m_lvl[i] = 7; m_spur[i] = 1'b1;
                end
            end
        end else if (m_phase[i] == 1) begin
            if (inta) begin
                m_phase[i] = 2;
                m_vec[i] = {vec_base, 3'(m_lvl[i])};
                m_voe[i] = 1'b1;
                if (auto_eoi && !m_spur[i]) nxt[m_lvl[i]] = 1'b0;
            end
        end else begin
            m_phase[i] = 0;
        end
        m_isr[i] = nxt;
        w2 = top_of(elig, i);
        t2 = top_of(nxt, i);
        m_int[i] = (w2 >= 0) && ((t2 < 0) || (pos_of(w2, i) < pos_of(t2, i)));
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else begin
            model_step(0, 1'b0);
            model_step(1, 1'b1);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("dut%0d int_out", i), {7'd0, int_out_v[i]}, {7'd0, m_int[i]});
                check($sformatf("dut%0d irr_clr", i), irr_clr_v[i], m_clr[i]);
                check($sformatf("dut%0d isr", i), isr_v[i], m_isr[i]);
                check($sformatf("dut%0d vector", i), vector_v[i], m_vec[i]);
                check($sformatf("dut%0d vector_oe", i), {7'd0, voe_v[i]}, {7'd0, m_voe[i]});
                check($sformatf("dut%0d state", i), {6'd0, st_v[i]}, 8'(m_phase[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inta();
        inta = 1'b1; tick(); inta = 1'b0;
    endtask

    task automatic pulse_eoi(input bit spec, input logic [2:0] lvl);
        eoi = 1'b1; eoi_specific = spec; eoi_level = lvl;
        tick();
        eoi = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        irr = 8'd0; imr = 8'd0;
    endtask

    // Full acknowledge of the single request in mask m; the IRR bit is
    // withdrawn after the first pulse as the IRR block would do.
    task automatic service(input logic [7:0] m);
        irr = m; pulse_inta(); irr = 8'd0; pulse_inta(); tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit prev_inta;
        #1;
        do_reset();
        cmp_en = 1'b1;
        check("reset isr", isr_v[0], 8'h00);
        check("reset state", {6'd0, st_v[0]}, 8'h00);

        // Basic acknowledge sequence
        irr = 8'h24; vec_base = 5'h01; tick();
        check("A int_out", {7'd0, int_out_v[0]}, 8'h01);
        pulse_inta();
        check("A isr", isr_v[0], 8'h04);
        check("A irr_clr", irr_clr_v[0], 8'h04);
        irr = 8'h20;
        pulse_inta();
        check("A vector", vector_v[0], 8'h0A);
        check("A vector_oe", {7'd0, voe_v[0]}, 8'h01);
        check("A auto_eoi isr", isr_v[1], 8'h00);
        tick();
        check("A vector hold", vector_v[0], 8'h0A);
        check("A vector_oe low", {7'd0, voe_v[0]}, 8'h00);

        // Nesting against IR2 in service
        irr = 8'h08; tick();
        check("B lower blocked", {7'd0, int_out_v[0]}, 8'h00);
        irr = 8'h02; tick();
        check("B higher nests", {7'd0, int_out_v[0]}, 8'h01);
        irr = 8'h00; pulse_eoi(1'b0, 3'd0);
        check("B eoi clears", isr_v[0], 8'h00);

        // Spurious acknowledge
        do_reset();
        irr = 8'h08; tick();
        irr = 8'h00; pulse_inta();
        check("C spurious isr", isr_v[0], 8'h00);
        check("C spurious irr_clr", irr_clr_v[0], 8'h00);
        pulse_inta();
        check("C spurious vector", vector_v[0], 8'h0F);
        tick();

        // EOI variants and EOI coinciding with INTA
        do_reset();
        service(8'h10);
        service(8'h02);
        check("D isr 0x12", isr_v[0], 8'h12);
        pulse_eoi(1'b0, 3'd0);
        check("D nonspecific", isr_v[0], 8'h10);
        pulse_eoi(1'b1, 3'd4);
        check("D specific 4", isr_v[0], 8'h00);
        service(8'h04);
        check("D isr 0x04", isr_v[0], 8'h04);
        irr = 8'h02; eoi = 1'b1; inta = 1'b1; tick(); eoi = 1'b0; inta = 1'b0;
        check("D eoi+inta isr", isr_v[0], 8'h02);
        check("D eoi+inta irr_clr", irr_clr_v[0], 8'h02);
        irr = 8'h00; pulse_inta(); tick();

        // Rotation after non-specific EOI
        do_reset();
        service(8'h08);
        pulse_eoi(1'b0, 3'd0);
        irr = 8'h88; tick();
        pulse_inta();
`ifdef PIC_AUTO_ROTATE_EN
        check("E rotated winner", isr_v[0], 8'h80);
        check("E rotated irr_clr", irr_clr_v[0], 8'h80);
`else
        check("E fixed winner", isr_v[0], 8'h08);
        check("E fixed irr_clr", irr_clr_v[0], 8'h08);
`endif
        irr = 8'h00; pulse_inta(); tick();

        // Reset in the middle of an acknowledge
        do_reset();
        irr = 8'h01; tick();
        pulse_inta();
        check("F in ACK1", {6'd0, st_v[0]}, 8'h01);
        #2 reset = 1'b1;
        #1;
        check("F async isr", isr_v[0], 8'h00);
        check("F async int_out", {7'd0, int_out_v[0]}, 8'h00);
        check("F async state", {6'd0, st_v[0]}, 8'h00);
        check("F async irr_clr", irr_clr_v[0], 8'h00);
        tick(); reset = 1'b0;
        pulse_inta();
        check("F first ack again", {6'd0, st_v[0]}, 8'h01);
        check("F isr set", isr_v[0], 8'h01);
        pulse_inta();
        check("F vector", vector_v[0], 8'h08);
        check("F auto_eoi clears", isr_v[1], 8'h00);
        irr = 8'h00; tick();

        // Randomized traffic against the model
        do_reset();
        prev_inta = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                inta = 1'b0; eoi = 1'b0;
                reset = 1'b1; tick(); reset = 1'b0;
            end
            irr          = 8'($urandom_range(0, 255));
            imr          = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'd0;
            inta         = prev_inta ? 1'b0 : ($urandom_range(0, 2) == 0);
            eoi          = ($urandom_range(0, 5) == 0);
            eoi_specific = 1'($urandom_range(0, 1));
            eoi_level    = 3'($urandom_range(0, 7));
            vec_base     = 5'($urandom_range(0, 31));
            prev_inta    = inta;
            tick();
        end
        inta = 1'b0; eoi = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/priority_isr_ctrl.md
PRIORITY_ISR_CTRL -- requirements
Module: priority_isr_ctrl

Interface
REQ-001 SHALL have parameter AUTO_EOI, default 0; 1 = clear the ISR bit automatically at the second acknowledge.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port irr  input  8  pending requests from the interrupt request register; bit n = IRn.
REQ-005 SHALL have port imr  input  8  mask; 1 = IRn blocked.
REQ-006 SHALL have port inta  input  1  acknowledge pulse, one clk wide, synchronous to clk.
REQ-007 SHALL have port eoi  input  1  end-of-interrupt command pulse, one clk wide.
REQ-008 SHALL have port eoi_specific  input  1  qualifies eoi; 1 = clear level eoi_level, 0 = non-specific.
REQ-009 SHALL have port eoi_level  input  3  target level for a specific EOI.
REQ-010 SHALL have port vec_base  input  5  upper vector bits (T7..T3).
REQ-011 SHALL have port int_out  output  1  interrupt request to CPU.
REQ-012 SHALL have port irr_clr  output  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit.
REQ-013 SHALL have port isr  output  8  in-service register.
REQ-014 SHALL have port vector  output  8  interrupt vector {vec_base, level}.
REQ-015 SHALL have port vector_oe  output  1  vector valid, one cycle.

Function
REQ-016 Eligible set SHALL be irr & ~imr.
REQ-017 Priority SHALL be fixed, IR0 highest, IR7 lowest, unless REQ-031 applies.
REQ-018 int_out SHALL be registered: 1 when the highest eligible request outranks the highest-priority set isr bit (fully nested); it reflects inputs sampled one cycle earlier.
REQ-019 FSM states SHALL be IDLE, ACK1, ACK2.
REQ-020 IDLE + inta SHALL latch the winning level L into ACK1, set isr[L], pulse irr_clr[L] for that cycle, and drop int_out the following cycle.
REQ-021 If no eligible request exists at the first inta (spurious), L SHALL be 7, isr SHALL be unchanged, and irr_clr SHALL be 0.
REQ-022 ACK1 + inta SHALL drive vector = {vec_base, L} with vector_oe=1 for exactly that cycle and go to ACK2.
REQ-023 ACK2 SHALL return to IDLE unconditionally on the next cycle.
REQ-024 With AUTO_EOI=1, the ACK1→ACK2 transition SHALL also clear isr[L]; a spurious cycle clears nothing.
REQ-025 A non-specific eoi SHALL clear the highest-priority set isr bit; a specific eoi SHALL clear isr[eoi_level]. eoi with isr=0 SHALL be a no-op.
REQ-026 When eoi and inta coincide, the EOI clear SHALL act on the pre-cycle isr and the inta set SHALL apply afterwards. The bit just set SHALL survive.
REQ-027 inta in ACK2 SHALL be ignored.
REQ-028 vector SHALL hold its last value when vector_oe=0.

Reset
REQ-029 Asserting reset SHALL immediately force: state IDLE, isr=0, int_out=0, irr_clr=0, vector=0, vector_oe=0, rotation pointer so IR0 is highest.
REQ-030 Reset mid-acknowledge SHALL abandon the sequence. The next inta after release is treated as a first acknowledge.

Configuration
REQ-031 With macro PIC_AUTO_ROTATE_EN defined, each non-specific eoi SHALL rotate priority so that the level it cleared becomes lowest priority, and priority resolution SHALL use the rotated order. A specific eoi SHALL not rotate.
REQ-032 Without PIC_AUTO_ROTATE_EN, priority SHALL stay fixed, IR0 highest, and no rotation logic SHALL be present.

Verification
REQ-033 The bench SHALL cover: irr=0x24, imr=0, vec_base=0x01 → int_out=1; inta → isr=0x04, irr_clr=0x04; second inta → vector=0x0A, vector_oe=1.
REQ-034 The bench SHALL cover: isr=0x04 in service, irr=0x08 → int_out=0; irr=0x02 → int_out=1 (nesting).
REQ-035 The bench SHALL cover: irr withdrawn to 0 before the first inta → isr unchanged, irr_clr=0, vector={vec_base,3'b111}.
REQ-036 The bench SHALL cover: isr=0x12, non-specific eoi → isr=0x10; specific eoi with level 4 → isr=0x00; eoi and inta in the same cycle, with isr=0x04 and a new IR1 → isr=0x02.
REQ-037 The bench SHALL cover, with PIC_AUTO_ROTATE_EN: service IR3, then non-specific eoi, then irr=0x88 → IR7 wins (priority order IR4..IR3). Without the macro, IR3 wins.
REQ-038 The bench SHALL cover: reset asserted in ACK1 → isr=0, int_out=0, state IDLE immediately; with AUTO_EOI=1, isr returns to 0 after the second inta.
